// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared result codes, score increments and FSM encoding for step_judge
package ddr_pkg;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_MISS    = 2'b01;
  localparam logic [1:0] RES_GOOD    = 2'b10;
  localparam logic [1:0] RES_PERFECT = 2'b11;

  localparam logic [1:0] SCORE_PERFECT = 2'd2;
  localparam logic [1:0] SCORE_GOOD    = 2'd1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/step_edge_detect.sv
// rtl/step_edge_detect.sv - 4-bit rising-edge detector for one player's buttons
//   clock  in   system clock
//   reset  in   asynchronous active-high reset
//   btn    in   [3:0] synchronous button levels
//   rise   out  [3:0] one-cycle high where btn went 0->1
module step_edge_detect (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] rise
);

  logic [3:0] btn_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) btn_q <= 4'b0000;
    else       btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/step_judge.sv
// rtl/step_judge.sv - per-note timing judge for two players with score and combo
//   clock, reset            system clock, asynchronous active-high reset
//   a_btn, b_btn            [3:0] debounced button levels per player
//   note_valid/note_dir     note offer from the chart sequencer (dir one-hot)
//   note_ready              high while IDLE
//   a_res_valid/a_res       one-cycle judgement pulse and code, player A
//   b_res_valid/b_res       same for player B
//   a_score/b_score         saturating score
//   a_combo/b_combo         saturating consecutive non-MISS count
//   Optional: STEP_JUDGE_EARLY_PENALTY_EN - a rise while IDLE clears that player's combo
module step_judge
  import ddr_pkg::*;
#(
  parameter int WINDOW    = 16,
  parameter int PERFECT_W = 4,
  parameter int SCORE_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         a_btn,
  input  logic [3:0]         b_btn,
  input  logic               note_valid,
  input  logic [3:0]         note_dir,
  output logic               note_ready,
  output logic               a_res_valid,
  output logic               b_res_valid,
  output logic [1:0]         a_res,
  output logic [1:0]         b_res,
  output logic [SCORE_W-1:0] a_score,
  output logic [SCORE_W-1:0] b_score,
  output logic [SCORE_W-1:0] a_combo,
  output logic [SCORE_W-1:0] b_combo
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         dir;
  logic               a_done, b_done;
  logic [3:0]         a_rise, b_rise;
  logic               last;
  logic               a_judge, b_judge;
  logic [1:0]         a_code, b_code;

  step_edge_detect u_edge_a (.clock(clock), .reset(reset), .btn(a_btn), .rise(a_rise));
  step_edge_detect u_edge_b (.clock(clock), .reset(reset), .btn(b_btn), .rise(b_rise));

  function automatic logic [1:0] grade(input logic [3:0] rise, input logic [3:0] target,
                                       input logic [CNT_W-1:0] t);
    // No rise here means the window timed out on this player.
    if (rise == 4'b0000)     return RES_MISS;
    else if (rise != target) return RES_MISS;
    else if (t < CNT_W'(PERFECT_W)) return RES_PERFECT;
    else                     return RES_GOOD;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v,
                                                 input logic [1:0] inc);
    logic [SCORE_W:0] s;
    s = {1'b0, v} + (SCORE_W + 1)'(inc);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [1:0] score_inc(input logic [1:0] code);
    if (code == RES_PERFECT)   return SCORE_PERFECT;
    else if (code == RES_GOOD) return SCORE_GOOD;
    else                       return 2'd0;
  endfunction

  assign note_ready = (state == ST_IDLE);
  assign last       = (cnt == CNT_W'(WINDOW - 1));

  // A press in the last cycle is judged in place of the timeout MISS.
  assign a_judge = (state == ST_ARMED) && !a_done && ((a_rise != 4'b0000) || last);
  assign b_judge = (state == ST_ARMED) && !b_done && ((b_rise != 4'b0000) || last);
  assign a_code  = grade(a_rise, dir, cnt);
  assign b_code  = grade(b_rise, dir, cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dir         <= 4'b0000;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      a_res_valid <= 1'b0;
      b_res_valid <= 1'b0;
      a_res       <= RES_NONE;
      b_res       <= RES_NONE;
      a_score     <= '0;
      b_score     <= '0;
      a_combo     <= '0;
      b_combo     <= '0;
    end else begin
      a_res_valid <= 1'b0;
      b_res_valid <= 1'b0;
      a_res       <= RES_NONE;
      b_res       <= RES_NONE;
      case (state)
        ST_IDLE: begin
          if (note_valid) begin
            dir    <= note_dir;
            cnt    <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            state  <= ST_ARMED;
          end
`ifdef STEP_JUDGE_EARLY_PENALTY_EN
          if (a_rise != 4'b0000) a_combo <= '0;
          if (b_rise != 4'b0000) b_combo <= '0;
`endif
        end
        ST_ARMED: begin
          cnt <= cnt + CNT_W'(1);
          if (a_judge) begin
            a_done      <= 1'b1;
            a_res_valid <= 1'b1;
            a_res       <= a_code;
            a_score     <= sat_add(a_score, score_inc(a_code));
            a_combo     <= (a_code == RES_MISS) ? '0 : sat_add(a_combo, 2'd1);
          end
          if (b_judge) begin
            b_done      <= 1'b1;
            b_res_valid <= 1'b1;
            b_res       <= b_code;
            b_score     <= sat_add(b_score, score_inc(b_code));
            b_combo     <= (b_code == RES_MISS) ? '0 : sat_add(b_combo, 2'd1);
          end
          if (last || ((a_done || a_judge) && (b_done || b_judge))) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
